voice_allocator: RTL and testbench

Scheduler that shares the synthesizer's voice pipelines among incoming MIDI note events. Sits between the MIDI message path and the per-voice pipelines: accepts note-on/note-off events over a valid/ready handshake, picks a target voice (same-key retrigger, idle voice, releasing voice, or oldest voice stolen), and issues a one-cycle command to exactly one pipeline. Keeps a per-voice key/age table so note-offs reach the voice that owns the key.

---
 rtl/voice_allocator_pkg.sv | 31 +++
 rtl/voice_allocator_age_table.sv | 91 +++++++++
 rtl/voice_allocator.sv | 278 +++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// voice_allocator_pkg
// Shared types and defaults for the voice allocator and its age table.
//   alloc_state_t : scheduler states (IDLE, SEARCH, ISSUE, FLUSH)
//   voice_cmd_t   : latched note event / command payload (on, key, velocity)
//   sat_inc16     : saturating 16-bit increment used by the steal counter
// -----------------------------------------------------------------------------
package voice_allocator_pkg;

    localparam int VOICE_COUNT_DEF = 8;
    localparam int KEY_WIDTH_DEF   = 7;
    localparam int VEL_WIDTH_DEF   = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_FLUSH  = 2'd3
    } alloc_state_t;

    typedef struct packed {
        logic                     on;
        logic [KEY_WIDTH_DEF-1:0] key;
        logic [VEL_WIDTH_DEF-1:0] velocity;
    } voice_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/voice_allocator_age_table.sv
// -----------------------------------------------------------------------------
// voice_age_table
// Per-voice state: allocated flag, key, age (0 = newest) and, when SUSTAIN_EN
// is defined, a sustained flag. Applies the age bookkeeping on each update.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_upd_on       : claim voice i_idx for key i_key (retrigger/free/steal)
//   i_upd_off      : release voice i_idx (also clears its sustained flag)
//   i_set_sus      : mark voice i_idx sustained (SUSTAIN_EN only)
//   o_alloc/o_key/o_age/o_sus : table contents
// -----------------------------------------------------------------------------
module voice_age_table
    import voice_allocator_pkg::*;
#(
    parameter int VOICE_COUNT = VOICE_COUNT_DEF,
    parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
    parameter int AGE_WIDTH   = $clog2(VOICE_COUNT_DEF)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_upd_on,
    input  logic                                  i_upd_off,
`ifdef SUSTAIN_EN
    input  logic                                  i_set_sus,
    output logic [VOICE_COUNT-1:0]                o_sus,
`endif
    input  logic [AGE_WIDTH-1:0]                  i_idx,
    input  logic [KEY_WIDTH-1:0]                  i_key,
    output logic [VOICE_COUNT-1:0]                o_alloc,
    output logic [VOICE_COUNT-1:0][KEY_WIDTH-1:0] o_key,
    output logic [VOICE_COUNT-1:0][AGE_WIDTH-1:0] o_age
);

    logic [VOICE_COUNT-1:0]                r_alloc;
    logic [VOICE_COUNT-1:0][KEY_WIDTH-1:0] r_key;
    logic [VOICE_COUNT-1:0][AGE_WIDTH-1:0] r_age;
`ifdef SUSTAIN_EN
    logic [VOICE_COUNT-1:0]                r_sus;
    assign o_sus = r_sus;
`endif

    logic                 w_v_alloc;
    logic [AGE_WIDTH-1:0] w_v_age;

    assign w_v_alloc = r_alloc[i_idx];
    assign w_v_age   = r_age[i_idx];
    assign o_alloc   = r_alloc;
    assign o_key     = r_key;
    assign o_age     = r_age;

    // Table update: a claimed voice becomes newest, a released voice closes its age gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc <= '0;
            r_key   <= '0;
            r_age   <= '0;
`ifdef SUSTAIN_EN
            r_sus   <= '0;
`endif
        end else if (i_upd_on) begin
            // If the voice was free every sounding voice gets older; otherwise
            // only those younger than its previous age do, keeping ages distinct.
            for (int i = 0; i < VOICE_COUNT; i++) begin
                if ((AGE_WIDTH'(i) != i_idx) && r_alloc[i] &&
                    (!w_v_alloc || (r_age[i] < w_v_age))) begin
                    r_age[i] <= r_age[i] + AGE_WIDTH'(1);
                end
            end
            r_alloc[i_idx] <= 1'b1;
            r_age[i_idx]   <= '0;
            r_key[i_idx]   <= i_key;
`ifdef SUSTAIN_EN
            r_sus[i_idx]   <= 1'b0;
`endif
        end else if (i_upd_off) begin
            for (int i = 0; i < VOICE_COUNT; i++) begin
                if (r_alloc[i] && (r_age[i] > w_v_age)) begin
                    r_age[i] <= r_age[i] - AGE_WIDTH'(1);
                end
            end
            r_alloc[i_idx] <= 1'b0;
            r_age[i_idx]   <= '0;
`ifdef SUSTAIN_EN
            r_sus[i_idx]   <= 1'b0;
        end else if (i_set_sus) begin
            r_sus[i_idx]   <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Schedules MIDI note events onto VOICE_COUNT voice pipelines. An accepted
// event is compared against one voice per cycle, then a one-cycle one-hot
// command is issued to the chosen voice (retrigger > idle > releasing > steal
// oldest). Note-offs go to the voice owning the key, or are dropped.
// Optional feature macro: SUSTAIN_EN (sustain pedal hold and flush).
// Ports:
//   clock_50_000_000, reset       : clock, synchronous active-high reset
//   note_valid/note_ready         : event handshake
//   note_on/note_key/note_velocity: event payload
//   voice_busy                    : per-voice release tail still sounding
//   sustain                       : pedal level (SUSTAIN_EN only)
//   voice_cmd_valid/_on/_key/_velocity : registered command to the pipelines
//   steal_count                   : saturating count of stolen voices
// -----------------------------------------------------------------------------
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICE_COUNT = VOICE_COUNT_DEF,
    parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
    parameter int VEL_WIDTH   = VEL_WIDTH_DEF
) (
    input  logic                   clock_50_000_000,
    input  logic                   reset,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic                   note_on,
    input  logic [KEY_WIDTH-1:0]   note_key,
    input  logic [VEL_WIDTH-1:0]   note_velocity,
    input  logic [VOICE_COUNT-1:0] voice_busy,
    input  logic                   sustain,
    output logic [VOICE_COUNT-1:0] voice_cmd_valid,
    output logic                   voice_cmd_on,
    output logic [KEY_WIDTH-1:0]   voice_cmd_key,
    output logic [VEL_WIDTH-1:0]   voice_cmd_velocity,
    output logic [15:0]            steal_count
);

    localparam int IW = $clog2(VOICE_COUNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(VOICE_COUNT - 1);

    alloc_state_t           r_state;
    voice_cmd_t             r_evt;
    logic [IW-1:0]          r_idx, r_vidx;
    logic                   r_hit_rt, r_hit_free, r_hit_fbusy, r_hit_old;
    logic [IW-1:0]          r_rt_idx, r_free_idx, r_fbusy_idx, r_old_idx, r_old_age;
    logic                   r_ready, r_cmd_on;
    logic [VOICE_COUNT-1:0] r_cmd_valid;
    logic [KEY_WIDTH-1:0]   r_cmd_key;
    logic [VEL_WIDTH-1:0]   r_cmd_vel;
    logic [15:0]            r_steal_count;

    logic [VOICE_COUNT-1:0]                w_alloc;
    logic [VOICE_COUNT-1:0][KEY_WIDTH-1:0] w_key;
    logic [VOICE_COUNT-1:0][IW-1:0]        w_age;
    logic [KEY_WIDTH-1:0] w_evt_key;
    logic [VEL_WIDTH-1:0] w_evt_vel;
    logic                 w_rt_take, w_free_take, w_fbusy_take, w_old_take;
    logic                 w_nx_hit_rt, w_nx_hit_free, w_nx_hit_fbusy, w_nx_hit_old;
    logic [IW-1:0]        w_nx_rt_idx, w_nx_free_idx, w_nx_fbusy_idx, w_nx_old_idx;
    logic [IW-1:0]        w_dec_vidx, w_upd_idx;
    logic                 w_dec_steal, w_do_issue, w_pend, w_off_hold;
    logic                 w_upd_on, w_upd_off;

`ifdef SUSTAIN_EN
    logic                   r_sus_lvl, r_flush_pend;
    logic [VOICE_COUNT-1:0] w_sus;
    logic                   w_fl_any, w_set_sus;
    logic [IW-1:0]          w_fl_idx;

    assign w_pend     = r_flush_pend;
    assign w_off_hold = r_sus_lvl;
    assign w_set_sus  = (r_state == ST_SEARCH) && (r_idx == LAST_IDX) && !r_evt.on &&
                        w_nx_hit_rt && r_sus_lvl;

    // Lowest-index sustained voice is flushed first.
    always_comb begin
        w_fl_any = 1'b0;
        w_fl_idx = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            w_fl_idx = w_sus[i] ? IW'(i) : w_fl_idx;
            w_fl_any = w_fl_any | w_sus[i];
        end
    end
`else
    logic w_unused_sustain;
    assign w_unused_sustain = sustain;
    assign w_pend     = 1'b0;
    assign w_off_hold = 1'b0;
`endif

    assign w_evt_key = KEY_WIDTH'(r_evt.key);
    assign w_evt_vel = VEL_WIDTH'(r_evt.velocity);

    // First hit per class, folding in the voice examined this cycle.
    assign w_rt_take     = !r_hit_rt && w_alloc[r_idx] && (w_key[r_idx] == w_evt_key);
    assign w_free_take   = !r_hit_free && !w_alloc[r_idx] && !voice_busy[r_idx];
    assign w_fbusy_take  = !r_hit_fbusy && !w_alloc[r_idx] && voice_busy[r_idx];
    assign w_old_take    = w_alloc[r_idx] && (!r_hit_old || (w_age[r_idx] > r_old_age));
    assign w_nx_hit_rt    = r_hit_rt | w_rt_take;
    assign w_nx_hit_free  = r_hit_free | w_free_take;
    assign w_nx_hit_fbusy = r_hit_fbusy | w_fbusy_take;
    assign w_nx_hit_old   = r_hit_old | w_old_take;
    assign w_nx_rt_idx    = w_rt_take ? r_idx : r_rt_idx;
    assign w_nx_free_idx  = w_free_take ? r_idx : r_free_idx;
    assign w_nx_fbusy_idx = w_fbusy_take ? r_idx : r_fbusy_idx;
    assign w_nx_old_idx   = w_old_take ? r_idx : r_old_idx;

    // Target selection by priority; steal only when every voice is allocated.
    always_comb begin
        w_dec_vidx  = w_nx_old_idx;
        w_dec_steal = 1'b0;
        if (w_nx_hit_rt) begin
            w_dec_vidx = w_nx_rt_idx;
        end else if (w_nx_hit_free) begin
            w_dec_vidx = w_nx_free_idx;
        end else if (w_nx_hit_fbusy) begin
            w_dec_vidx = w_nx_fbusy_idx;
        end else begin
            w_dec_steal = 1'b1;
        end
    end

    // A held note-off (pedal down) never issues; it only marks the voice sustained.
    assign w_do_issue = r_evt.on || (w_nx_hit_rt && !w_off_hold);
    assign w_upd_on   = (r_state == ST_ISSUE) && r_evt.on;
`ifdef SUSTAIN_EN
    assign w_upd_off  = ((r_state == ST_ISSUE) && !r_evt.on) || ((r_state == ST_FLUSH) && w_fl_any);
    assign w_upd_idx  = (r_state == ST_FLUSH) ? w_fl_idx : r_vidx;
`else
    assign w_upd_off  = (r_state == ST_ISSUE) && !r_evt.on;
    assign w_upd_idx  = r_vidx;
`endif

    voice_age_table #(
        .VOICE_COUNT (VOICE_COUNT),
        .KEY_WIDTH   (KEY_WIDTH),
        .AGE_WIDTH   (IW)
    ) u_table (
        .clk       (clock_50_000_000),
        .reset     (reset),
        .i_upd_on  (w_upd_on),
        .i_upd_off (w_upd_off),
`ifdef SUSTAIN_EN
        .i_set_sus (w_set_sus),
        .o_sus     (w_sus),
`endif
        .i_idx     (w_upd_idx),
        .i_key     (w_evt_key),
        .o_alloc   (w_alloc),
        .o_key     (w_key),
        .o_age     (w_age)
    );

    // Scheduler FSM with registered handshake and command outputs.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_evt         <= '0;
            r_idx         <= '0;
            r_vidx        <= '0;
            r_hit_rt      <= 1'b0;
            r_hit_free    <= 1'b0;
            r_hit_fbusy   <= 1'b0;
            r_hit_old     <= 1'b0;
            r_rt_idx      <= '0;
            r_free_idx    <= '0;
            r_fbusy_idx   <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_ready       <= 1'b0;
            r_cmd_valid   <= '0;
            r_cmd_on      <= 1'b0;
            r_cmd_key     <= '0;
            r_cmd_vel     <= '0;
            r_steal_count <= 16'd0;
`ifdef SUSTAIN_EN
            r_sus_lvl     <= 1'b0;
            r_flush_pend  <= 1'b0;
`endif
        end else begin
            r_cmd_valid <= '0;
            case (r_state)
                ST_IDLE: begin
`ifdef SUSTAIN_EN
                    if (r_flush_pend) begin
                        r_state      <= ST_FLUSH;
                        r_flush_pend <= 1'b0;
                        r_ready      <= 1'b0;
                    end else
`endif
                    if (note_valid && r_ready) begin
                        r_state        <= ST_SEARCH;
                        r_ready        <= 1'b0;
                        r_idx          <= '0;
                        r_hit_rt       <= 1'b0;
                        r_hit_free     <= 1'b0;
                        r_hit_fbusy    <= 1'b0;
                        r_hit_old      <= 1'b0;
                        r_old_age      <= '0;
                        r_evt.on       <= note_on;
                        r_evt.key      <= KEY_WIDTH_DEF'(note_key);
                        r_evt.velocity <= VEL_WIDTH_DEF'(note_velocity);
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    r_hit_rt    <= w_nx_hit_rt;
                    r_hit_free  <= w_nx_hit_free;
                    r_hit_fbusy <= w_nx_hit_fbusy;
                    r_hit_old   <= w_nx_hit_old;
                    r_rt_idx    <= w_nx_rt_idx;
                    r_free_idx  <= w_nx_free_idx;
                    r_fbusy_idx <= w_nx_fbusy_idx;
                    r_old_idx   <= w_nx_old_idx;
                    r_old_age   <= w_old_take ? w_age[r_idx] : r_old_age;
                    if (r_idx == LAST_IDX) begin
                        if (w_do_issue) begin
                            r_state     <= ST_ISSUE;
                            r_vidx      <= r_evt.on ? w_dec_vidx : w_nx_rt_idx;
                            r_cmd_valid <= VOICE_COUNT'(1) << (r_evt.on ? w_dec_vidx : w_nx_rt_idx);
                            r_cmd_on    <= r_evt.on;
                            r_cmd_key   <= w_evt_key;
                            r_cmd_vel   <= r_evt.on ? w_evt_vel : '0;
                            if (r_evt.on && w_dec_steal) begin
                                r_steal_count <= sat_inc16(r_steal_count);
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= !w_pend;
                        end
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_IDLE;
                    r_ready <= !w_pend;
                end
`ifdef SUSTAIN_EN
                ST_FLUSH: begin
                    if (w_fl_any) begin
                        r_cmd_valid <= VOICE_COUNT'(1) << w_fl_idx;
                        r_cmd_on    <= 1'b0;
                        r_cmd_key   <= w_key[w_fl_idx];
                        r_cmd_vel   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= !r_flush_pend;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
`ifdef SUSTAIN_EN
            // Pedal release schedules a flush; it takes priority over new events.
            r_sus_lvl <= sustain;
            if (r_sus_lvl && !sustain) begin
                r_flush_pend <= 1'b1;
                r_ready      <= 1'b0;
            end
`endif
        end
    end

    assign note_ready         = r_ready;
    assign voice_cmd_valid    = r_cmd_valid;
    assign voice_cmd_on       = r_cmd_on;
    assign voice_cmd_key      = r_cmd_key;
    assign voice_cmd_velocity = r_cmd_vel;
    assign steal_count        = r_steal_count;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Directed, table-driven bench for voice_allocator (8 voices, 7-bit key/vel).
// Each row optionally resets, sets voice_busy, sends one event and checks the
// strobe, its timing, the command fields and steal_count. Hand-written
// sequences cover reset values, reset during SEARCH and (with SUSTAIN_EN) the
// pedal flush.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

    logic       clock_50_000_000 = 1'b0;
    logic       reset = 1'b1;
    logic       note_valid = 1'b0;
    logic       note_ready;
    logic       note_on = 1'b0;
    logic [6:0] note_key = 7'd0;
    logic [6:0] note_velocity = 7'd0;
    logic [7:0] voice_busy = 8'h00;
    logic       sustain = 1'b0;
    logic [7:0] voice_cmd_valid;
    logic       voice_cmd_on;
    logic [6:0] voice_cmd_key;
    logic [6:0] voice_cmd_velocity;
    logic [15:0] steal_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         rst;
        logic [7:0] busy;
        bit         on;
        logic [6:0] key;
        logic [6:0] vel;
        logic [7:0] exp_strobe;
        logic [15:0] exp_steal;
    } vec_t;

    vec_t vq[$];

    voice_allocator dut (
        .clock_50_000_000   (clock_50_000_000),
        .reset              (reset),
        .note_valid         (note_valid),
        .note_ready         (note_ready),
        .note_on            (note_on),
        .note_key           (note_key),
        .note_velocity      (note_velocity),
        .voice_busy         (voice_busy),
        .sustain            (sustain),
        .voice_cmd_valid    (voice_cmd_valid),
        .voice_cmd_on       (voice_cmd_on),
        .voice_cmd_key      (voice_cmd_key),
        .voice_cmd_velocity (voice_cmd_velocity),
        .steal_count        (steal_count)
    );

    always #10 clock_50_000_000 = ~clock_50_000_000;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, n, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, logic [7:0] busy, bit on, int key, int vel,
                                logic [7:0] strobe, int steal);
        vec_t v;
        v.rst = rst; v.busy = busy; v.on = on; v.key = 7'(key); v.vel = 7'(vel);
        v.exp_strobe = strobe; v.exp_steal = 16'(steal);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clock_50_000_000);
        reset = 1'b1;
        note_valid = 1'b0;
        repeat (2) @(negedge clock_50_000_000);
        reset = 1'b0;
        @(negedge clock_50_000_000);
    endtask

    task automatic wait_ready(input int n);
        int k = 0;
        while (!note_ready && k < 40) begin
            @(negedge clock_50_000_000);
            k++;
        end
        check("ready_before", n, 32'(note_ready), 32'd1);
    endtask

    // Sends one event and checks strobe, latency and fields.
    task automatic run_vec(input int n, input vec_t v);
        int strobes = 0, scyc = -1, rcyc = -1;
        logic [7:0] seen = 8'h00;
        logic s_on = 1'b0;
        logic [6:0] s_key = 7'd0, s_vel = 7'd0;
        if (v.rst) do_reset();
        voice_busy = v.busy;
        wait_ready(n);
        note_valid = 1'b1; note_on = v.on; note_key = v.key; note_velocity = v.vel;
        for (int c = 1; c <= 30 && rcyc < 0; c++) begin
            @(negedge clock_50_000_000);
            if (c == 1) note_valid = 1'b0;
            if (voice_cmd_valid != 8'h00) begin
                strobes++; seen = voice_cmd_valid; scyc = c;
                s_on = voice_cmd_on; s_key = voice_cmd_key; s_vel = voice_cmd_velocity;
            end
            if (note_ready) rcyc = c;
        end
        check("strobe", n, 32'(seen), 32'(v.exp_strobe));
        check("n_strobes", n, 32'(strobes), (v.exp_strobe != 8'h00) ? 32'd1 : 32'd0);
        check("ready_lat", n, 32'(rcyc), (v.exp_strobe != 8'h00) ? 32'd10 : 32'd9);
        if (v.exp_strobe != 8'h00) begin
            check("strobe_cyc", n, 32'(scyc), 32'd9);
            check("cmd_on", n, 32'(s_on), 32'(v.on));
            check("cmd_key", n, 32'(s_key), 32'(v.key));
            check("cmd_vel", n, 32'(s_vel), v.on ? 32'(v.vel) : 32'd0);
        end
        check("steal", n, 32'(steal_count), 32'(v.exp_steal));
    endtask

    initial begin
        int strobes;
        // Reset values
        repeat (2) @(negedge clock_50_000_000);
        check("rst_ready", 0, 32'(note_ready), 32'd0);
        check("rst_valid", 0, 32'(voice_cmd_valid), 32'd0);
        check("rst_key", 0, 32'(voice_cmd_key), 32'd0);
        check("rst_vel", 0, 32'(voice_cmd_velocity), 32'd0);
        check("rst_steal", 0, 32'(steal_count), 32'd0);
        reset = 1'b0;
        @(negedge clock_50_000_000);
        check("rst_ready_after", 0, 32'(note_ready), 32'd1);

        // Scenario A: allocation, release, retrigger, unmatched off, steals
        vq.push_back(mk(1, 8'h00, 1, 60, 100, 8'h01, 0));
        vq.push_back(mk(0, 8'h00, 1, 62,  90, 8'h02, 0));
        vq.push_back(mk(0, 8'h00, 1, 64,  80, 8'h04, 0));
        vq.push_back(mk(0, 8'h00, 0, 62,   0, 8'h02, 0));
        vq.push_back(mk(0, 8'h00, 1, 65,  70, 8'h02, 0));
        vq.push_back(mk(0, 8'h00, 1, 60,  50, 8'h01, 0));
        vq.push_back(mk(0, 8'h00, 0, 99,   0, 8'h00, 0));
        vq.push_back(mk(0, 8'h00, 1, 66,  10, 8'h08, 0));
        vq.push_back(mk(0, 8'h00, 1, 67,  11, 8'h10, 0));
        vq.push_back(mk(0, 8'h00, 1, 68,  12, 8'h20, 0));
        vq.push_back(mk(0, 8'h00, 1, 69,  13, 8'h40, 0));
        vq.push_back(mk(0, 8'h00, 1, 71,  14, 8'h80, 0));
        vq.push_back(mk(0, 8'h00, 1, 72,  15, 8'h04, 1));
        vq.push_back(mk(0, 8'h00, 0, 64,   0, 8'h00, 1));
        vq.push_back(mk(0, 8'h00, 1, 73,  16, 8'h02, 2));
        vq.push_back(mk(0, 8'h00, 0, 60,   0, 8'h01, 2));
        // Scenario C: fill 60..67, steal voice 0 with 70
        for (int i = 0; i < 8; i++) vq.push_back(mk(i == 0, 8'h00, 1, 60 + i, 20 + i, 8'(1 << i), 0));
        vq.push_back(mk(0, 8'h00, 1, 70, 99, 8'h01, 1));
        vq.push_back(mk(0, 8'h00, 0, 60,  0, 8'h00, 1));
        vq.push_back(mk(0, 8'h00, 0, 61,  0, 8'h02, 1));
        // Scenario B: busy (releasing) voices are second choice
        vq.push_back(mk(1, 8'h01, 1, 40, 30, 8'h02, 0));
        vq.push_back(mk(1, 8'hFF, 1, 41, 31, 8'h01, 0));
        vq.push_back(mk(0, 8'hFE, 1, 42, 32, 8'h02, 0));
        // Scenario D: duplicate note-on keeps one voice
        vq.push_back(mk(1, 8'h00, 1, 60, 40, 8'h01, 0));
        vq.push_back(mk(0, 8'h00, 1, 60, 41, 8'h01, 0));
        vq.push_back(mk(0, 8'h00, 1, 61, 42, 8'h02, 0));
        for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

        // Reset during SEARCH drops the event and clears the table
        do_reset();
        run_vec(100, mk(0, 8'h00, 1, 50, 10, 8'h01, 0));
        wait_ready(101);
        note_valid = 1'b1; note_on = 1'b1; note_key = 7'd60; note_velocity = 7'd60;
        @(negedge clock_50_000_000);
        note_valid = 1'b0;
        repeat (3) @(negedge clock_50_000_000);
        reset = 1'b1;
        strobes = 0;
        @(negedge clock_50_000_000);
        check("midrst_ready", 101, 32'(note_ready), 32'd0);
        check("midrst_valid", 101, 32'(voice_cmd_valid), 32'd0);
        @(negedge clock_50_000_000);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock_50_000_000);
            if (voice_cmd_valid != 8'h00) strobes++;
        end
        check("midrst_strobes", 101, 32'(strobes), 32'd0);
        check("midrst_ready_after", 101, 32'(note_ready), 32'd1);
        check("midrst_key", 101, 32'(voice_cmd_key), 32'd0);
        run_vec(102, mk(0, 8'h00, 1, 61, 20, 8'h01, 0));

`ifdef SUSTAIN_EN
        begin
            logic [7:0] fs[2];
            logic [6:0] fk[2];
            logic       fo[2];
            int         fc[2];
            int         ns = 0;
            do_reset();
            sustain = 1'b1;
            repeat (2) @(negedge clock_50_000_000);
            run_vec(200, mk(0, 8'h00, 1, 60, 100, 8'h01, 0));
            run_vec(201, mk(0, 8'h00, 1, 64,  90, 8'h02, 0));
            run_vec(202, mk(0, 8'h00, 0, 60,   0, 8'h00, 0));
            run_vec(203, mk(0, 8'h00, 0, 64,   0, 8'h00, 0));
            sustain = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clock_50_000_000);
                if (voice_cmd_valid != 8'h00) begin
                    if (ns < 2) begin
                        fs[ns] = voice_cmd_valid; fk[ns] = voice_cmd_key;
                        fo[ns] = voice_cmd_on; fc[ns] = c;
                    end
                    ns++;
                end
            end
            check("flush_count", 204, 32'(ns), 32'd2);
            if (ns >= 2) begin
                check("flush_v0", 204, 32'(fs[0]), 32'h01);
                check("flush_v1", 204, 32'(fs[1]), 32'h02);
                check("flush_k0", 204, 32'(fk[0]), 32'd60);
                check("flush_k1", 204, 32'(fk[1]), 32'd64);
                check("flush_on", 204, 32'({fo[0], fo[1]}), 32'd0);
                check("flush_gap", 204, 32'(fc[1] - fc[0]), 32'd1);
            end
            check("flush_ready", 204, 32'(note_ready), 32'd1);
            run_vec(205, mk(0, 8'h00, 1, 70, 70, 8'h01, 0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
